// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Package: hazard_pkg
// Shared types and constants for the pipeline hazard controller.
// Contents: fwd_sel_e (operand forward select), hz_state_e (wait FSM state),
// and RESULT_SRC_LOAD (ResultSrcE encoding of a load instruction).
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_e;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        FAULT    = 2'b10
    } hz_state_e;

    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Interface: pipeline_hazard_ctrl_if
// Bundles the pipeline-side hazard information and the stall/flush/forward
// controls. master = pipeline datapath, slave = hazard controller.
// Inputs to controller: Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE, PCSrcE, RdM,
//   RegWriteM, MemAccessM, MemReadyM, RdW, RegWriteW.
// Outputs of controller: StallF/D/E/M, FlushD/E/W, ForwardAE/BE, MemFault.
// Optional macro HAZARD_PERF_EN adds StallCycles and FlushCount.
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_WIDTH = 32
);
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic [1:0] ResultSrcE;
    logic       PCSrcE, RegWriteM, MemAccessM, MemReadyM, RegWriteW;
    logic       StallF, StallD, StallE, StallM;
    logic       FlushD, FlushE, FlushW;
    logic [1:0] ForwardAE, ForwardBE;
    logic       MemFault;
`ifdef HAZARD_PERF_EN
    logic [CNT_WIDTH-1:0] StallCycles, FlushCount;
`endif

    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE, PCSrcE, RdM, RegWriteM,
               MemAccessM, MemReadyM, RdW, RegWriteW,
        input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
               ForwardAE, ForwardBE, MemFault
`ifdef HAZARD_PERF_EN
               , StallCycles, FlushCount
`endif
    );

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE, PCSrcE, RdM, RegWriteM,
               MemAccessM, MemReadyM, RdW, RegWriteW,
        output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
               ForwardAE, ForwardBE, MemFault
`ifdef HAZARD_PERF_EN
               , StallCycles, FlushCount
`endif
    );
endinterface

// File: rtl/pipeline_hazard_ctrl_fwd_sel.sv
// Module: hazard_fwd_sel
// Forward select for one E-stage source operand. The M-stage result is newer
// than the W-stage result, so M wins; x0 is never forwarded.
// Ports: rs_i (source reg in E), rd_m_i/reg_write_m_i, rd_w_i/reg_write_w_i,
//        fwd_o (FWD_RF / FWD_W / FWD_M).
module hazard_fwd_sel
    import hazard_pkg::*;
(
    input  logic [4:0] rs_i,
    input  logic [4:0] rd_m_i,
    input  logic       reg_write_m_i,
    input  logic [4:0] rd_w_i,
    input  logic       reg_write_w_i,
    output fwd_sel_e   fwd_o
);

    // Select the newest in-flight producer of rs_i
    always_comb begin
        fwd_o = FWD_RF;
        if (reg_write_m_i && (rd_m_i != 5'd0) && (rd_m_i == rs_i)) begin
            fwd_o = FWD_M;
        end else if (reg_write_w_i && (rd_w_i != 5'd0) && (rd_w_i == rs_i)) begin
            fwd_o = FWD_W;
        end else begin
            fwd_o = FWD_RF;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Module: pipeline_hazard_ctrl
// Stall/flush/forward control for a 5-stage pipeline. Handles load-use,
// taken-branch redirect and variable-latency data memory; a wait FSM freezes
// the pipeline during a memory wait and latches a sticky MemFault on timeout.
// Ports: clk, rst (synchronous, active-high), hz (pipeline_hazard_ctrl_if.slave).
// Parameters: MEM_TIMEOUT (1..65535), CNT_WIDTH (perf counter width).
// Optional macro HAZARD_PERF_EN adds saturating StallCycles / FlushCount.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    pipeline_hazard_ctrl_if.slave hz
);

    hz_state_e   state_q, state_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;
    fwd_sel_e    fwd_a_s, fwd_b_s;
    logic        memwait_s, lw_stall_s;
    logic        stall_f_s, stall_d_s, stall_e_s, stall_m_s;
    logic        flush_d_s, flush_e_s, flush_w_s;
    logic [1:0]  fwd_a_out_s, fwd_b_out_s;
    logic        fault_s;

    hazard_fwd_sel u_fwd_a (
        .rs_i(hz.Rs1E), .rd_m_i(hz.RdM), .reg_write_m_i(hz.RegWriteM),
        .rd_w_i(hz.RdW), .reg_write_w_i(hz.RegWriteW), .fwd_o(fwd_a_s)
    );

    hazard_fwd_sel u_fwd_b (
        .rs_i(hz.Rs2E), .rd_m_i(hz.RdM), .reg_write_m_i(hz.RegWriteM),
        .rd_w_i(hz.RdW), .reg_write_w_i(hz.RegWriteW), .fwd_o(fwd_b_s)
    );

    // Memory wait is Mealy so the freeze happens in the same cycle
    assign memwait_s  = hz.MemAccessM && !hz.MemReadyM;
    // A taken branch in E squashes the dependent instruction in D anyway
    assign lw_stall_s = (hz.ResultSrcE == RESULT_SRC_LOAD) && (hz.RdE != 5'd0) &&
                        ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D)) && !hz.PCSrcE;

    // State and wait-counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            wait_cnt_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Next-state logic of the memory-wait FSM
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            RUN: begin
                if (memwait_s) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = 16'd1;
                end else begin
                    wait_cnt_d = 16'd0;
                end
            end
            MEM_WAIT: begin
                if (!memwait_s) begin
                    state_d    = RUN;
                    wait_cnt_d = 16'd0;
                end else if (wait_cnt_q == 16'(MEM_TIMEOUT)) begin
                    state_d = FAULT;
                end else if (wait_cnt_q != 16'hFFFF) begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end else begin
                    wait_cnt_d = wait_cnt_q;
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = 16'd0;
            end
        endcase
    end

    // Output decode: FAULT > memwait > redirect > load-use; all zero in reset
    always_comb begin
        stall_f_s   = 1'b0;
        stall_d_s   = 1'b0;
        stall_e_s   = 1'b0;
        stall_m_s   = 1'b0;
        flush_d_s   = 1'b0;
        flush_e_s   = 1'b0;
        flush_w_s   = 1'b0;
        fwd_a_out_s = 2'b00;
        fwd_b_out_s = 2'b00;
        fault_s     = 1'b0;
        if (!rst) begin
            fwd_a_out_s = fwd_a_s;
            fwd_b_out_s = fwd_b_s;
            if (state_q == FAULT) begin
                // Hold the front end, let M/W drain
                fault_s   = 1'b1;
                stall_f_s = 1'b1;
                stall_d_s = 1'b1;
                flush_e_s = 1'b1;
            end else if (memwait_s) begin
                // Freeze everything; the pending branch in E is held with it
                stall_f_s = 1'b1;
                stall_d_s = 1'b1;
                stall_e_s = 1'b1;
                stall_m_s = 1'b1;
                flush_w_s = 1'b1;
            end else if (hz.PCSrcE) begin
                flush_d_s = 1'b1;
                flush_e_s = 1'b1;
            end else if (lw_stall_s) begin
                stall_f_s = 1'b1;
                stall_d_s = 1'b1;
                flush_e_s = 1'b1;
            end else begin
                stall_f_s = 1'b0;
            end
        end else begin
            fault_s = 1'b0;
        end
    end

    assign hz.StallF    = stall_f_s;
    assign hz.StallD    = stall_d_s;
    assign hz.StallE    = stall_e_s;
    assign hz.StallM    = stall_m_s;
    assign hz.FlushD    = flush_d_s;
    assign hz.FlushE    = flush_e_s;
    assign hz.FlushW    = flush_w_s;
    assign hz.ForwardAE = fwd_a_out_s;
    assign hz.ForwardBE = fwd_b_out_s;
    assign hz.MemFault  = fault_s;

`ifdef HAZARD_PERF_EN
    logic [CNT_WIDTH-1:0] stall_cycles_q, flush_count_q;

    // Saturating performance counters
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q <= {CNT_WIDTH{1'b0}};
            flush_count_q  <= {CNT_WIDTH{1'b0}};
        end else begin
            if (stall_f_s && (stall_cycles_q != {CNT_WIDTH{1'b1}})) begin
                stall_cycles_q <= stall_cycles_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end else begin
                stall_cycles_q <= stall_cycles_q;
            end
            if (flush_e_s && (flush_count_q != {CNT_WIDTH{1'b1}})) begin
                flush_count_q <= flush_count_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end else begin
                flush_count_q <= flush_count_q;
            end
        end
    end

    assign hz.StallCycles = stall_cycles_q;
    assign hz.FlushCount  = flush_count_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Testbench for pipeline_hazard_ctrl: directed scenarios followed by random
// stimulus, checked against a behavioural model through a scoreboard queue.
module tb_pipeline_hazard_ctrl;

    localparam int TIMEOUT = 4;
    localparam int CW      = 32;

    typedef struct {
        bit       rst;
        bit [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
        bit [1:0] ressrc;
        bit       pcsrc, rwm, memacc, memrdy, rww;
    } stim_t;

    // {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW,FwdA,FwdB,MemFault}
    typedef logic [11:0] out_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    out_t exp_q[$];

    // model state
    bit  m_fault   = 1'b0;
    bit  m_waiting = 1'b0;
    int  m_len     = 0;
    longint m_stalls = 0;
    longint m_flushes = 0;

    pipeline_hazard_ctrl_if #(.CNT_WIDTH(CW)) hz_if ();

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(TIMEOUT), .CNT_WIDTH(CW)) dut (
        .clk(clk),
        .rst(rst),
        .hz (hz_if.slave)
    );

    always #5 clk = ~clk;

    function automatic bit [1:0] ref_fwd(bit [4:0] rs, bit [4:0] rdm, bit rwm,
                                         bit [4:0] rdw, bit rww);
        if (rwm && rdm != 0 && rdm == rs) return 2'b10;
        if (rww && rdw != 0 && rdw == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic out_t ref_out(stim_t s);
        bit sf, sd, se, sm, fd, fe, fw, flt;
        bit mw, lw;
        sf = 0; sd = 0; se = 0; sm = 0; fd = 0; fe = 0; fw = 0; flt = 0;
        if (s.rst) return 12'd0;
        mw = s.memacc && !s.memrdy;
        lw = (s.ressrc == 2'b01) && s.rde != 0 && (s.rde == s.rs1d || s.rde == s.rs2d);
        if (m_fault) begin
            flt = 1; sf = 1; sd = 1; fe = 1;
        end else if (mw) begin
            sf = 1; sd = 1; se = 1; sm = 1; fw = 1;
        end else if (s.pcsrc) begin
            fd = 1; fe = 1;
        end else if (lw) begin
            sf = 1; sd = 1; fe = 1;
        end
        return {sf, sd, se, sm, fd, fe, fw,
                ref_fwd(s.rs1e, s.rdm, s.rwm, s.rdw, s.rww),
                ref_fwd(s.rs2e, s.rdm, s.rwm, s.rdw, s.rww), flt};
    endfunction

    task automatic apply(input stim_t s);
        out_t e;
        @(posedge clk);
        #1;
        rst              = s.rst;
        hz_if.Rs1D       = s.rs1d;
        hz_if.Rs2D       = s.rs2d;
        hz_if.Rs1E       = s.rs1e;
        hz_if.Rs2E       = s.rs2e;
        hz_if.RdE        = s.rde;
        hz_if.ResultSrcE = s.ressrc;
        hz_if.PCSrcE     = s.pcsrc;
        hz_if.RdM        = s.rdm;
        hz_if.RegWriteM  = s.rwm;
        hz_if.MemAccessM = s.memacc;
        hz_if.MemReadyM  = s.memrdy;
        hz_if.RdW        = s.rdw;
        hz_if.RegWriteW  = s.rww;
        e = ref_out(s);
        exp_q.push_back(e);
        // advance model to the state after the coming edge
        if (s.rst) begin
            m_fault = 0; m_waiting = 0; m_len = 0; m_stalls = 0; m_flushes = 0;
        end else begin
            m_stalls  += e[11];
            m_flushes += e[6];
            if (!m_fault) begin
                if (s.memacc && !s.memrdy) begin
                    if (!m_waiting) begin
                        m_waiting = 1; m_len = 1;
                    end else if (m_len == TIMEOUT) begin
                        m_fault = 1;
                    end else begin
                        m_len++;
                    end
                end else begin
                    m_waiting = 0; m_len = 0;
                end
            end
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '{default: 0};
        s.memrdy = 1;
        return s;
    endfunction

    // Monitor: outputs are valid every cycle; compare on the falling edge
    always @(negedge clk) begin
        out_t a, e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {hz_if.StallF, hz_if.StallD, hz_if.StallE, hz_if.StallM,
                 hz_if.FlushD, hz_if.FlushE, hz_if.FlushW,
                 hz_if.ForwardAE, hz_if.ForwardBE, hz_if.MemFault};
            n_checks++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL outputs @%0t: actual=%b required=%b (SF SD SE SM FD FE FW FA FB MF)",
                         $time, a, e);
            end
        end
    end

`ifdef HAZARD_PERF_EN
    task automatic check_perf(input longint es, input longint ef, input string tag);
        n_checks++;
        if (hz_if.StallCycles !== CW'(es) || hz_if.FlushCount !== CW'(ef)) begin
            n_fail++;
            $display("FAIL perf_%s: actual stalls=%0d flushes=%0d required stalls=%0d flushes=%0d",
                     tag, hz_if.StallCycles, hz_if.FlushCount, es, ef);
        end
    endtask
`endif

    initial begin
        stim_t s;
        int    wait_cyc;
        rst = 1'b1;
        s = idle(); s.rst = 1;
        apply(s);
        apply(s);

        // forwarding: M wins over W, then W when RdM is x0
        s = idle(); s.rdm = 5; s.rwm = 1; s.rdw = 5; s.rww = 1; s.rs1e = 5; s.rs2e = 5;
        apply(s);
        s.rdm = 0;
        apply(s);

        // load-use: one bubble, then the load moves on
        s = idle(); s.ressrc = 2'b01; s.rde = 7; s.rs2d = 7;
        apply(s);
        s = idle(); s.rdm = 7; s.rwm = 1; s.memacc = 1; s.rs2e = 7;
        apply(s);

        // memory wait with pending redirect: 3 frozen cycles then redirect
        s = idle(); s.memacc = 1; s.memrdy = 0; s.pcsrc = 1;
        repeat (3) apply(s);
        s.memrdy = 1;
        apply(s);
        apply(idle());
`ifdef HAZARD_PERF_EN
        check_perf(64'd4, 64'd2, "directed");
`endif

        // redirect beats load-use
        s = idle(); s.pcsrc = 1; s.ressrc = 2'b01; s.rde = 7; s.rs1d = 7;
        apply(s);
        apply(idle());

        // timeout into sticky fault, held through ready, then cleared by reset
        s = idle(); s.memacc = 1; s.memrdy = 0;
        repeat (8) apply(s);
        apply(idle());
        s = idle(); s.rst = 1;
        apply(s);
        apply(idle());

        // random phase with small register indices for frequent matches
        for (int i = 0; i < 800; i++) begin
            s.rst    = ($urandom_range(0, 59) == 0);
            s.rs1d   = 5'($urandom_range(0, 3));
            s.rs2d   = 5'($urandom_range(0, 3));
            s.rs1e   = 5'($urandom_range(0, 3));
            s.rs2e   = 5'($urandom_range(0, 3));
            s.rde    = 5'($urandom_range(0, 3));
            s.rdm    = 5'($urandom_range(0, 3));
            s.rdw    = 5'($urandom_range(0, 3));
            s.ressrc = 2'($urandom_range(0, 3));
            s.pcsrc  = ($urandom_range(0, 4) == 0);
            s.rwm    = 1'($urandom);
            s.rww    = 1'($urandom);
            s.memacc = ($urandom_range(0, 2) != 0);
            s.memrdy = ($urandom_range(0, 9) < 3);
            apply(s);
        end
        apply(idle());
        apply(idle());
`ifdef HAZARD_PERF_EN
        check_perf(m_stalls, m_flushes, "random");
`endif

        wait_cyc = 0;
        while (exp_q.size() > 0 && wait_cyc < 10) begin
            @(posedge clk);
            wait_cyc++;
        end
        n_checks++;
        if (exp_q.size() > 0) begin
            n_fail++;
            $display("FAIL drain: actual pending=%0d required pending=0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
